up_down_cntr_mod: RTL and testbench



---
 rtl/up_down_cntr_mod.sv | 73 +++++++
 tb/tb_up_down_cntr_mod.sv | 118 +++++++++++
 2 files changed

// File: rtl/up_down_cntr_mod.sv
// up_down_cntr_mod: bounded up/down modulo counter with variable step, load, wrap/saturate
// and optional sticky ovf/unf status built when UP_DOWN_CNTR_STS_EN is defined.
module up_down_cntr_mod #(
   parameter int N      = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  logic              ld,
   input  logic [N-1:0]      ld_val,
   input  logic [N-1:0]      lo,
   input  logic [N-1:0]      hi,
   input  logic              sat,
   input  logic              clr_sts,
   output logic [N-1:0]      dout,
   output logic              tc,
   output logic              ovf,
   output logic              unf
);
   logic [N:0]   sum;
   logic [N:0]   lo_step;
   logic [N-1:0] dout_nxt;
   logic         cnt;
   logic         up_evt;
   logic         dn_evt;
   logic         evt;
   // Boundary detection in N+1 bits so carry out of dout+step and lo+step is kept.
   always_comb begin
      sum      = {1'b0, dout} + (N+1)'(step);
      lo_step  = {1'b0, lo} + (N+1)'(step);
      cnt      = en && !ld && (step != '0);
      up_evt   = sum > {1'b0, hi};
      dn_evt   = {1'b0, dout} < lo_step;
      evt      = up ? up_evt : dn_evt;
      dout_nxt = up ? (up_evt ? (sat ? hi : lo) : sum[N-1:0])
                    : (dn_evt ? (sat ? lo : hi) : dout - N'(step));
   end
   // Count register and terminal-count pulse; rst beats ld beats en.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
         tc   <= 1'b0;
      end else if (ld) begin
         dout <= ld_val;
         tc   <= 1'b0;
      end else if (cnt) begin
         dout <= dout_nxt;
         tc   <= evt;
      end else begin
         tc   <= 1'b0;
      end
   end
`ifdef UP_DOWN_CNTR_STS_EN
   // Sticky boundary flags; a new event outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= (cnt && up && up_evt) || (ovf && !clr_sts);
         unf <= (cnt && !up && dn_evt) || (unf && !clr_sts);
      end
   end
`else
   logic unused_clr_sts;
   assign unused_clr_sts = clr_sts;
   assign ovf = 1'b0;
   assign unf = 1'b0;
`endif
endmodule

// File: tb/tb_up_down_cntr_mod.sv
// tb_up_down_cntr_mod: directed self-checking bench for up_down_cntr_mod at N=4, STEP_W=2.
module tb_up_down_cntr_mod;
   logic       clk = 1'b0;
   logic       rst, en, up, ld, sat, clr_sts;
   logic [1:0] step;
   logic [3:0] ld_val, lo, hi;
   logic [3:0] dout;
   logic       tc, ovf, unf;
   int         checks = 0;
   int         errors = 0;
`ifdef UP_DOWN_CNTR_STS_EN
   logic sts = 1'b1;
`else
   logic sts = 1'b0;
`endif

   up_down_cntr_mod #(.N(4), .STEP_W(2)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .ld(ld), .ld_val(ld_val),
      .lo(lo), .hi(hi), .sat(sat), .clr_sts(clr_sts),
      .dout(dout), .tc(tc), .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   // Advance one edge, then compare all outputs; o/u are the flag values with status built.
   task automatic cyc(input string tag, input logic [3:0] d, input logic t, input logic o, input logic u);
      logic eo, eu;
      eo = o & sts;
      eu = u & sts;
      @(posedge clk);
      #1;
      checks++;
      assert (dout === d) else begin errors++; $error("FAIL %s dout got %0d want %0d", tag, dout, d); end
      checks++;
      assert (tc === t) else begin errors++; $error("FAIL %s tc got %b want %b", tag, tc, t); end
      checks++;
      assert (ovf === eo) else begin errors++; $error("FAIL %s ovf got %b want %b", tag, ovf, eo); end
      checks++;
      assert (unf === eu) else begin errors++; $error("FAIL %s unf got %b want %b", tag, unf, eu); end
   endtask

   initial begin
      rst = 1; en = 0; up = 1; ld = 0; sat = 0; clr_sts = 0;
      step = 2'd1; ld_val = 4'd0; lo = 4'd0; hi = 4'd15;
      cyc("reset0", 4'd0, 0, 0, 0);
      cyc("reset1", 4'd0, 0, 0, 0);
      // full-range wrap up
      rst = 0; en = 1;
      for (int i = 1; i <= 15; i++) cyc("full_up", 4'(i), 0, 0, 0);
      cyc("full_wrap", 4'd0, 1, 1, 0);
      // holds
      en = 0;
      for (int i = 0; i < 5; i++) cyc("hold_en0", 4'd0, 0, 1, 0);
      en = 1; step = 2'd0;
      for (int i = 0; i < 5; i++) cyc("hold_step0", 4'd0, 0, 1, 0);
      // windowed wrap with step 2
      ld = 1; ld_val = 4'd3; lo = 4'd3; hi = 4'd9; step = 2'd2; en = 0;
      cyc("win_ld", 4'd3, 0, 1, 0);
      ld = 0; en = 1;
      cyc("win_5", 4'd5, 0, 1, 0);
      cyc("win_7", 4'd7, 0, 1, 0);
      cyc("win_9", 4'd9, 0, 1, 0);
      cyc("win_wrap", 4'd3, 1, 1, 0);
      // status clear race
      cyc("race_5", 4'd5, 0, 1, 0);
      cyc("race_7", 4'd7, 0, 1, 0);
      cyc("race_9", 4'd9, 0, 1, 0);
      clr_sts = 1;
      cyc("race_set_wins", 4'd3, 1, 1, 0);
      en = 0;
      cyc("race_clear", 4'd3, 0, 0, 0);
      clr_sts = 0;
      // saturate down
      ld = 1; ld_val = 4'd4; lo = 4'd2; step = 2'd3; up = 0; sat = 1;
      cyc("satdn_ld", 4'd4, 0, 0, 0);
      ld = 0; en = 1;
      cyc("satdn_evt", 4'd2, 1, 0, 1);
      cyc("satdn_hold1", 4'd2, 1, 0, 1);
      cyc("satdn_hold2", 4'd2, 1, 0, 1);
      // down counting then wrap to hi
      ld = 1; ld_val = 4'd10; hi = 4'd15; sat = 0;
      cyc("dn_ld", 4'd10, 0, 0, 1);
      ld = 0;
      cyc("dn_7", 4'd7, 0, 0, 1);
      cyc("dn_4", 4'd4, 0, 0, 1);
      cyc("dn_wrap", 4'd15, 1, 0, 1);
      // saturate up
      ld = 1; ld_val = 4'd8; lo = 4'd0; hi = 4'd9; up = 1; sat = 1;
      cyc("satup_ld", 4'd8, 0, 0, 1);
      ld = 0;
      cyc("satup_evt", 4'd9, 1, 1, 1);
      cyc("satup_hold", 4'd9, 1, 1, 1);
      // out-of-range load above hi
      ld = 1; ld_val = 4'd14; lo = 4'd3; sat = 0; step = 2'd1;
      cyc("oor_ld", 4'd14, 0, 1, 1);
      ld = 0;
      cyc("oor_up", 4'd3, 1, 1, 1);
      // carry beyond N bits
      ld = 1; ld_val = 4'd15; lo = 4'd0; hi = 4'd15; step = 2'd3;
      cyc("carry_ld", 4'd15, 0, 1, 1);
      ld = 0;
      cyc("carry_wrap", 4'd0, 1, 1, 1);
      // borrow below zero
      ld = 1; ld_val = 4'd1; step = 2'd2; up = 0;
      cyc("borrow_ld", 4'd1, 0, 1, 1);
      ld = 0;
      cyc("borrow_wrap", 4'd15, 1, 1, 1);
      // priority: ld over en, then rst over en
      ld = 1; ld_val = 4'd12; up = 1; step = 2'd1;
      cyc("prio_ld", 4'd12, 0, 1, 1);
      ld = 0; rst = 1;
      cyc("prio_rst", 4'd0, 0, 0, 0);
      rst = 0; en = 0;
      cyc("post_rst", 4'd0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
